// File: rtl/pcs_pkg.sv
// Shared PCS TX definitions: sync headers, the idle control block and controller state types.
package pcs_pkg;

    localparam int unsigned BLK_DATA_W = 64;
    localparam int unsigned HDR_W      = 2;
    localparam int unsigned WORD_W     = 32;

    localparam logic [HDR_W-1:0]      SYNC_DATA     = 2'b01;
    localparam logic [HDR_W-1:0]      SYNC_CTRL     = 2'b10;
    localparam logic [7:0]            BLK_TYPE_IDLE = 8'h1E;
    localparam logic [BLK_DATA_W-1:0] IDLE_BLOCK    = {56'h0, BLK_TYPE_IDLE};

    typedef enum logic [1:0] {
        ST_RESET,
        ST_INIT,
        ST_RUN
    } ctrl_state_t;

    typedef enum logic {
        PH_LO,
        PH_HI
    } phase_t;

    // One 66-bit encoded block: sync header above the payload.
    typedef struct packed {
        logic [HDR_W-1:0]      hdr;
        logic [BLK_DATA_W-1:0] data;
    } pcs_blk_t;

    localparam pcs_blk_t IDLE_BLK = '{hdr: SYNC_CTRL, data: IDLE_BLOCK};

endpackage

// File: rtl/pcs_cadence_mon.sv
// Watches the gearbox pause cadence: words between pauses must be PAUSE_PERIOD-1; raises a sticky error.
module pcs_cadence_mon #(
    parameter int unsigned PAUSE_PERIOD = 32
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_valid,
    input  logic i_pause,
    output logic o_cadence_err
);

    localparam int unsigned       CNT_W   = 6;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(PAUSE_PERIOD);
    localparam logic [CNT_W-1:0]  CNT_EXP = CNT_W'(PAUSE_PERIOD - 1);

    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic             seen_pause_q, seen_pause_d;
    logic             err_q, err_d;

    // The first pause only aligns the counter; later pauses are checked against it.
    always_comb begin
        word_cnt_d   = word_cnt_q;
        seen_pause_d = seen_pause_q;
        err_d        = err_q;
        if (i_pause) begin
            if (seen_pause_q && (word_cnt_q != CNT_EXP)) begin
                err_d = 1'b1;
            end
            seen_pause_d = 1'b1;
            word_cnt_d   = '0;
        end else if (i_valid && (word_cnt_q != CNT_MAX)) begin
            word_cnt_d = word_cnt_q + 1'b1;
        end
        if (word_cnt_q == CNT_MAX) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            word_cnt_q   <= '0;
            seen_pause_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            word_cnt_q   <= word_cnt_d;
            seen_pause_q <= seen_pause_d;
            err_q        <= err_d;
        end
    end

    assign o_cadence_err = err_q;

endmodule

// File: rtl/pcs_tx_gearbox_ctrl.sv
// Feeds 66-bit encoded blocks to the 32-bit TX gearbox as low/high word pairs, inserting idles as needed.
// Optional statistics counters are enabled with the PCS_TX_GB_CTRL_STATS_EN macro.
module pcs_tx_gearbox_ctrl
    import pcs_pkg::*;
#(
    parameter int unsigned PAUSE_PERIOD     = 32,
    parameter int unsigned INIT_IDLE_BLOCKS = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic [BLK_DATA_W-1:0] i_blk_data,
    input  logic [HDR_W-1:0]      i_blk_hdr,
    input  logic                  i_blk_valid,
    output logic                  o_blk_ready,
    input  logic                  i_gb_pause,
    output logic [WORD_W-1:0]     o_gb_data,
    output logic [HDR_W-1:0]      o_gb_hdr,
    output logic                  o_gb_sob,
    output logic                  o_gb_valid,
    output logic                  o_cadence_err
`ifdef PCS_TX_GB_CTRL_STATS_EN
    ,
    output logic [15:0]           o_idle_ins_cnt,
    output logic [15:0]           o_pause_cnt
`endif
);

    localparam int unsigned            INIT_CNT_W = 4;
    localparam logic [INIT_CNT_W-1:0]  INIT_LAST  = INIT_CNT_W'(INIT_IDLE_BLOCKS - 1);

    ctrl_state_t           state_q, state_d;
    phase_t                phase_q, phase_d;
    pcs_blk_t              blk_q, blk_d;
    logic [INIT_CNT_W-1:0] init_cnt_q, init_cnt_d;
    logic                  valid_q, valid_d;

    logic advance_c;
    logic hi_adv_c;
    logic blk_ready_c;

    assign advance_c   = valid_q && !i_gb_pause;
    assign hi_adv_c    = advance_c && (phase_q == PH_HI);
    // Never claim acceptance in a cycle whose state is about to be discarded by reset.
    assign blk_ready_c = i_reset_n && hi_adv_c && (state_q == ST_RUN);

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        blk_d      = blk_q;
        init_cnt_d = init_cnt_q;
        valid_d    = valid_q;

        if (advance_c) begin
            phase_d = (phase_q == PH_LO) ? PH_HI : PH_LO;
        end

        case (state_q)
            ST_RESET: begin
                valid_d = 1'b1;
                state_d = ST_INIT;
            end
            ST_INIT: begin
                if (hi_adv_c) begin
                    blk_d      = IDLE_BLK;
                    init_cnt_d = init_cnt_q + 1'b1;
                    if (init_cnt_d >= INIT_LAST) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (hi_adv_c) begin
                    blk_d = i_blk_valid ? '{hdr: i_blk_hdr, data: i_blk_data} : IDLE_BLK;
                end
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q    <= ST_RESET;
            phase_q    <= PH_LO;
            blk_q      <= IDLE_BLK;
            init_cnt_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            blk_q      <= blk_d;
            init_cnt_q <= init_cnt_d;
            valid_q    <= valid_d;
        end
    end

    assign o_gb_data   = (phase_q == PH_LO) ? blk_q.data[WORD_W-1:0] : blk_q.data[BLK_DATA_W-1:WORD_W];
    assign o_gb_hdr    = blk_q.hdr;
    assign o_gb_sob    = (phase_q == PH_LO) && valid_q;
    assign o_gb_valid  = valid_q;
    assign o_blk_ready = blk_ready_c;

    pcs_cadence_mon #(
        .PAUSE_PERIOD (PAUSE_PERIOD)
    ) u_cadence_mon (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_valid       (valid_q),
        .i_pause       (i_gb_pause),
        .o_cadence_err (o_cadence_err)
    );

`ifdef PCS_TX_GB_CTRL_STATS_EN
    localparam int unsigned STAT_W = 16;

    logic [STAT_W-1:0] idle_ins_cnt_q, idle_ins_cnt_d;
    logic [STAT_W-1:0] pause_cnt_q, pause_cnt_d;

    // Idle insertions saturate; pause cycles wrap.
    always_comb begin
        idle_ins_cnt_d = idle_ins_cnt_q;
        pause_cnt_d    = pause_cnt_q;
        if (blk_ready_c && !i_blk_valid && (idle_ins_cnt_q != '1)) begin
            idle_ins_cnt_d = idle_ins_cnt_q + 1'b1;
        end
        if (i_gb_pause) begin
            pause_cnt_d = pause_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            idle_ins_cnt_q <= '0;
            pause_cnt_q    <= '0;
        end else begin
            idle_ins_cnt_q <= idle_ins_cnt_d;
            pause_cnt_q    <= pause_cnt_d;
        end
    end

    assign o_idle_ins_cnt = idle_ins_cnt_q;
    assign o_pause_cnt    = pause_cnt_q;
`endif

endmodule

// File: tb/tb_pcs_tx_gearbox_ctrl.sv
// Scoreboard bench for pcs_tx_gearbox_ctrl: accepted/inserted blocks queue up, a monitor checks every word.
module tb_pcs_tx_gearbox_ctrl;
    import pcs_pkg::*;

    logic        i_clk;
    logic        i_reset_n;
    logic [63:0] i_blk_data;
    logic [1:0]  i_blk_hdr;
    logic        i_blk_valid;
    logic        o_blk_ready;
    logic        i_gb_pause;
    logic [31:0] o_gb_data;
    logic [1:0]  o_gb_hdr;
    logic        o_gb_sob;
    logic        o_gb_valid;
    logic        o_cadence_err;
`ifdef PCS_TX_GB_CTRL_STATS_EN
    logic [15:0] o_idle_ins_cnt;
    logic [15:0] o_pause_cnt;
`endif

    pcs_tx_gearbox_ctrl #(
        .PAUSE_PERIOD     (32),
        .INIT_IDLE_BLOCKS (4)
    ) dut (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_blk_data    (i_blk_data),
        .i_blk_hdr     (i_blk_hdr),
        .i_blk_valid   (i_blk_valid),
        .o_blk_ready   (o_blk_ready),
        .i_gb_pause    (i_gb_pause),
        .o_gb_data     (o_gb_data),
        .o_gb_hdr      (o_gb_hdr),
        .o_gb_sob      (o_gb_sob),
        .o_gb_valid    (o_gb_valid),
        .o_cadence_err (o_cadence_err)
`ifdef PCS_TX_GB_CTRL_STATS_EN
        ,
        .o_idle_ins_cnt (o_idle_ins_cnt),
        .o_pause_cnt    (o_pause_cnt)
`endif
    );

    int       n_checks = 0;
    int       n_fail   = 0;
    pcs_blk_t exp_q[$];
    logic     exp_lo   = 1'b1;

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Expected blocks: an accepted upstream block, or an idle when ready pulses with nothing offered.
    always @(negedge i_clk) begin
        if (i_reset_n && o_blk_ready) begin
            exp_q.push_back(i_blk_valid ? pcs_blk_t'({i_blk_hdr, i_blk_data}) : IDLE_BLK);
        end
    end

    // Monitor: every valid word is compared; the expected half only moves on an advance.
    always @(negedge i_clk) begin
        pcs_blk_t e;
        if (!i_reset_n) begin
            exp_q.delete();
            exp_lo = 1'b1;
        end else if (o_gb_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL mon_underflow: word %0h presented with no expected block", o_gb_data);
            end else begin
                e = exp_q[0];
                check("mon_sob", 66'(o_gb_sob), 66'(exp_lo));
                if (exp_lo) begin
                    check("mon_lo_word", 66'(o_gb_data), 66'(e.data[31:0]));
                    check("mon_hdr", 66'(o_gb_hdr), 66'(e.hdr));
                end else begin
                    check("mon_hi_word", 66'(o_gb_data), 66'(e.data[63:32]));
                end
                if (!i_gb_pause) begin
                    if (!exp_lo) begin
                        void'(exp_q.pop_front());
                    end
                    exp_lo = !exp_lo;
                end
            end
        end
    end

    task automatic do_reset();
        i_reset_n   = 1'b0;
        i_blk_valid = 1'b0;
        i_gb_pause  = 1'b0;
        repeat (3) step();
        i_reset_n = 1'b1;
        repeat (4) exp_q.push_back(IDLE_BLK);
    endtask

    task automatic send_blk(input pcs_blk_t b, output int ncyc);
        i_blk_hdr   = b.hdr;
        i_blk_data  = b.data;
        i_blk_valid = 1'b1;
        ncyc        = 0;
        do begin
            @(negedge i_clk);
            ncyc++;
        end while (!o_blk_ready && ncyc < 20);
        if (!o_blk_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: block %0h not accepted in %0d cycles", b.data, ncyc);
        end
        step();
        i_blk_valid = 1'b0;
    endtask

    initial begin
        pcs_blk_t blk_a, blk_z, blk_y, blk_w;
        pcs_blk_t b2b[5];
        int       ncyc;

        i_reset_n   = 1'b0;
        i_blk_valid = 1'b0;
        i_blk_data  = '0;
        i_blk_hdr   = '0;
        i_gb_pause  = 1'b0;

        blk_a  = '{hdr: 2'b01, data: 64'hAAAA_BBBB_CCCC_DDDD};
        blk_z  = '{hdr: 2'b01, data: 64'h1111_2222_3333_4444};
        blk_y  = '{hdr: 2'b10, data: 64'h5555_6666_7777_8888};
        blk_w  = '{hdr: 2'b01, data: 64'h9999_AAAA_BBBB_CCCC};
        b2b[0] = blk_a;
        b2b[1] = blk_a;
        b2b[2] = '{hdr: 2'b10, data: 64'h0123_4567_89AB_CDEF};
        b2b[3] = '{hdr: 2'b00, data: 64'hFFFF_0000_FFFF_0000};
        b2b[4] = '{hdr: 2'b11, data: 64'h8000_0000_0000_0001};

        // Reset release and the forced idle sequence.
        do_reset();
        @(negedge i_clk);
        check("rst_valid", 66'(o_gb_valid), 66'(1'b0));
        check("rst_ready", 66'(o_blk_ready), 66'(1'b0));
        check("rst_sob", 66'(o_gb_sob), 66'(1'b0));
        check("rst_err", 66'(o_cadence_err), 66'(1'b0));
        for (int w = 1; w <= 8; w++) begin
            @(negedge i_clk);
            if (w == 1) begin
                check("init_first_valid", 66'(o_gb_valid), 66'(1'b1));
                check("init_first_word", 66'(o_gb_data), 66'(32'h0000_001E));
            end
            check("init_ready", 66'(o_blk_ready), 66'(w == 8));
        end

        // Single block and its two-cycle latency.
        step();
        send_blk(blk_a, ncyc);
        @(negedge i_clk);
        check("lat_lo_word", 66'(o_gb_data), 66'(32'hCCCC_DDDD));
        check("lat_lo_sob", 66'(o_gb_sob), 66'(1'b1));
        check("lat_lo_hdr", 66'(o_gb_hdr), 66'(2'b01));
        @(negedge i_clk);
        check("lat_hi_word", 66'(o_gb_data), 66'(32'hAAAA_BBBB));
        check("lat_hi_sob", 66'(o_gb_sob), 66'(1'b0));
        check("idle_slot_ready", 66'(o_blk_ready), 66'(1'b1));
        step();

        // Back-to-back stream, including the non-standard headers passed through.
        for (int i = 0; i < 5; i++) begin
            send_blk(b2b[i], ncyc);
            check("b2b_ready_spacing", 66'(ncyc), 66'(2));
        end

        // Pause on a high word while the next block is offered.
        send_blk(blk_z, ncyc);
        i_blk_hdr   = blk_y.hdr;
        i_blk_data  = blk_y.data;
        i_blk_valid = 1'b1;
        step();
        i_gb_pause = 1'b1;
        @(negedge i_clk);
        check("pause_hi_ready", 66'(o_blk_ready), 66'(1'b0));
        check("pause_hi_word", 66'(o_gb_data), 66'(32'h1111_2222));
        step();
        i_gb_pause = 1'b0;
        @(negedge i_clk);
        check("pause_hi_repeat", 66'(o_gb_data), 66'(32'h1111_2222));
        check("pause_hi_sob", 66'(o_gb_sob), 66'(1'b0));
        check("pause_next_ready", 66'(o_blk_ready), 66'(1'b1));
        step();
        i_blk_valid = 1'b0;
        @(negedge i_clk);
        check("pause_next_lo", 66'(o_gb_data), 66'(32'h7777_8888));
        check("pause_next_hdr", 66'(o_gb_hdr), 66'(2'b10));

        // Reset asserted while the high word of a block is on the bus.
        step();
        i_reset_n   = 1'b0;
        i_blk_hdr   = blk_w.hdr;
        i_blk_data  = blk_w.data;
        i_blk_valid = 1'b1;
        @(negedge i_clk);
        check("midrst_hi_word", 66'(o_gb_data), 66'(32'h5555_6666));
        check("midrst_ready", 66'(o_blk_ready), 66'(1'b0));
        step();
        i_blk_valid = 1'b0;
        @(negedge i_clk);
        check("midrst_valid", 66'(o_gb_valid), 66'(1'b0));
        do_reset();
        @(negedge i_clk);
        check("midrst_rel_valid", 66'(o_gb_valid), 66'(1'b0));
        @(negedge i_clk);
        check("midrst_restart_word", 66'(o_gb_data), 66'(32'h0000_001E));
        check("midrst_restart_hdr", 66'(o_gb_hdr), 66'(2'b10));
        repeat (12) @(negedge i_clk);

        // Cadence: exempt first pause, five correct periods, then a short one.
        do_reset();
        @(negedge i_clk);
        check("cad_rst_err", 66'(o_cadence_err), 66'(1'b0));
        step();
        step();
        i_gb_pause = 1'b1;
        step();
        i_gb_pause = 1'b0;
        for (int p = 0; p < 5; p++) begin
            repeat (31) step();
            i_gb_pause = 1'b1;
            @(negedge i_clk);
            check("cad_good_pause", 66'(o_cadence_err), 66'(1'b0));
            step();
            i_gb_pause = 1'b0;
            @(negedge i_clk);
            check("cad_good_after", 66'(o_cadence_err), 66'(1'b0));
        end
        repeat (20) step();
        i_gb_pause = 1'b1;
        @(negedge i_clk);
        check("cad_bad_pause_cycle", 66'(o_cadence_err), 66'(1'b0));
        step();
        i_gb_pause = 1'b0;
        @(negedge i_clk);
        check("cad_err_set", 66'(o_cadence_err), 66'(1'b1));
        repeat (3) @(negedge i_clk);
        check("cad_err_sticky", 66'(o_cadence_err), 66'(1'b1));

        // Reset clears the sticky flag; then run past the period without a pause.
        do_reset();
        @(negedge i_clk);
        check("rst_clears_err", 66'(o_cadence_err), 66'(1'b0));
        step();
        step();
        i_gb_pause = 1'b1;
        step();
        i_gb_pause = 1'b0;
        for (int w = 1; w <= 35; w++) begin
            @(negedge i_clk);
            if (w == 33) check("sat_not_yet", 66'(o_cadence_err), 66'(1'b0));
            if (w == 35) check("sat_err_set", 66'(o_cadence_err), 66'(1'b1));
        end

`ifdef PCS_TX_GB_CTRL_STATS_EN
        // Idle insertions counted only in run state; pause cycles counted.
        do_reset();
        @(negedge i_clk);
        check("stats_rst_idle", 66'(o_idle_ins_cnt), 66'(16'd0));
        check("stats_rst_pause", 66'(o_pause_cnt), 66'(16'd0));
        for (int w = 1; w <= 13; w++) begin
            @(negedge i_clk);
            if (w == 7) check("stats_init_idle", 66'(o_idle_ins_cnt), 66'(16'd0));
            if (w == 9) check("stats_idle_one", 66'(o_idle_ins_cnt), 66'(16'd1));
        end
        check("stats_idle_three", 66'(o_idle_ins_cnt), 66'(16'd3));
        send_blk(blk_a, ncyc);
        @(negedge i_clk);
        check("stats_accept_no_count", 66'(o_idle_ins_cnt), 66'(16'd3));
        step();
        i_gb_pause = 1'b1;
        step();
        step();
        i_gb_pause = 1'b0;
        @(negedge i_clk);
        check("stats_pause_cnt", 66'(o_pause_cnt), 66'(16'd2));
`endif

        repeat (4) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
